filter_window_3x3: RTL and testbench

Streaming 3x3 window generator that sits directly upstream of the median filter stage. It accepts one 8-bit pixel per cycle in raster order and keeps two line buffers plus a 3x3 shift window. For every pixel whose 3x3 neighbourhood lies fully inside the image, it emits a 72-bit window in the packing the filter stage consumes. Border pixels produce no window, so output frames are (IMG_WIDTH-2) x (IMG_HEIGHT-2).

---
 rtl/filter_window_3x3_if.sv | 26 ++
 rtl/filter_window_3x3.sv | 126 ++++++++++++
 tb/tb_filter_window_3x3.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/filter_window_3x3_if.sv
// Pixel-in / window-out bundle for the 3x3 window generator.
// The slave side is the window generator; the master side is whatever
// feeds pixels and consumes windows.
interface filter_window_3x3_if #(
  parameter int XW = 6,
  parameter int YW = 6
) ();
  logic [7:0]    pixel_in;
  logic          pixel_valid;
  logic          in_sof;
  logic [71:0]   window_out;
  logic          window_valid;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          frame_done;

  modport slave (
    input  pixel_in, pixel_valid, in_sof,
    output window_out, window_valid, out_x, out_y, frame_done
  );

  modport master (
    output pixel_in, pixel_valid, in_sof,
    input  window_out, window_valid, out_x, out_y, frame_done
  );
endinterface

// File: rtl/filter_window_3x3.sv
// Streaming 3x3 window generator feeding the median filter stage.
// Two line buffers hold the previous two lines; a 3x3 register window
// slides one column per accepted pixel. Only windows whose neighbourhood
// lies fully inside the image are flagged valid, so border pixels produce
// no output and frames shrink to (IMG_WIDTH-2) x (IMG_HEIGHT-2).
module filter_window_3x3 #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int XW         = $clog2(IMG_WIDTH),
  parameter int YW         = $clog2(IMG_HEIGHT)
) (
  input  logic clk,
  input  logic rst,
  filter_window_3x3_if.slave bus
);

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          accept;
  logic          last_col;
  logic          last_row;
  logic          inner;

  logic [7:0]    lb1 [IMG_WIDTH];
  logic [7:0]    lb2 [IMG_WIDTH];
  logic [7:0]    w   [3][3];

  logic [71:0]   win_flat;
  logic          win_valid_q;
  logic          frame_done_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  // Coordinate of the pixel being accepted; a start-of-frame pins it to (0,0)
  // regardless of where the counters had got to.
  always_comb begin
    accept   = bus.pixel_valid;
    cur_x    = bus.in_sof ? '0 : col;
    cur_y    = bus.in_sof ? '0 : row;
    last_col = (cur_x == XW'(IMG_WIDTH - 1));
    last_row = (cur_y == YW'(IMG_HEIGHT - 1));
    inner    = (cur_x >= XW'(2)) && (cur_y >= YW'(2));
  end

  // Raster counters: column wraps into the next row, and the last pixel of
  // the frame wraps both so back-to-back frames need no sof.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : cur_y + YW'(1);
      end else begin
        col <= cur_x + XW'(1);
        row <= cur_y;
      end
    end
  end

  // Line buffers age one line per write; contents are never visible until
  // both have been refilled in the current frame, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cur_x] <= lb1[cur_x];
      lb1[cur_x] <= bus.pixel_in;
    end
  end

  // Slide the window left and load the new right column (oldest line on top).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          w[i][j] <= '0;
        end
      end
    end else if (accept) begin
      for (int i = 0; i < 3; i++) begin
        w[i][0] <= w[i][1];
        w[i][1] <= w[i][2];
      end
      w[0][2] <= lb2[cur_x];
      w[1][2] <= lb1[cur_x];
      w[2][2] <= bus.pixel_in;
    end
  end

  // Output qualifiers and window-centre coordinates, one cycle after accept;
  // coordinates hold through idle cycles while valid/done drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
    end else begin
      win_valid_q  <= accept && inner;
      frame_done_q <= accept && inner && last_col && last_row;
      if (accept) begin
        out_x_q <= cur_x - XW'(1);
        out_y_q <= cur_y - YW'(1);
      end
    end
  end

  // Pack the window as row-major bytes, row 0 / col 0 in the low byte.
  always_comb begin
    win_flat = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        win_flat[i*24 + j*8 +: 8] = w[i][j];
      end
    end
  end

  assign bus.window_out   = win_flat;
  assign bus.window_valid = win_valid_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.out_x        = out_x_q;
  assign bus.out_y        = out_y_q;

endmodule

// File: tb/tb_filter_window_3x3.sv
// Self-checking bench for filter_window_3x3 on a 4x4 image.
// An image-based reference model pushes expected windows onto a scoreboard
// as pixels are driven; a negedge monitor pops and compares them.
module tb_filter_window_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int XW = 2;
  localparam int YW = 2;

  typedef struct packed {
    logic [71:0]   win;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  filter_window_3x3_if #(.XW(XW), .YW(YW)) bus ();

  filter_window_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   mx = 0;
  int   my = 0;
  logic [7:0] img [H][W];
  int   windows_seen = 0;
  int   fd_seen = 0;
  logic median_on = 1'b0;
  logic acc_q;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] median9(input logic [71:0] win);
    logic [7:0] v [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) v[i] = win[i*8 +: 8];
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < 8 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    return v[4];
  endfunction

  // Drive one cycle; when the pixel is valid, update the reference image and
  // push the expected window if its neighbourhood is fully inside the frame.
  task automatic applyStimulus(input logic [7:0] p, input logic v, input logic s);
    exp_t e;
    bus.pixel_in    = p;
    bus.pixel_valid = v;
    bus.in_sof      = s;
    if (v) begin
      if (s) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = p;
      if (mx >= 2 && my >= 2) begin
        e.win = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.win[i*24 + j*8 +: 8] = img[my-2+i][mx-2+j];
        e.x  = XW'(mx - 1);
        e.y  = YW'(my - 1);
        e.fd = (mx == W-1) && (my == H-1);
        sb.push_back(e);
      end
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic endTest(input string name, input int exp_windows, input int exp_fd);
    for (int k = 0; k < 3; k++) applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput({name, " scoreboard drained"}, 72'(sb.size()), 72'd0);
    checkOutput({name, " window count"}, 72'(windows_seen), 72'(exp_windows));
    checkOutput({name, " frame_done count"}, 72'(fd_seen), 72'(exp_fd));
    sb.delete();
    windows_seen = 0;
    fd_seen = 0;
  endtask

  // Tracks whether a pixel was accepted on the most recent edge.
  always @(posedge clk or posedge rst) begin
    if (rst) acc_q <= 1'b0;
    else     acc_q <= bus.pixel_valid;
  end

  // Monitor: pop the scoreboard on every valid window and compare it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.window_valid) begin
        windows_seen++;
        if (bus.frame_done) fd_seen++;
        checkOutput("valid follows accepted pixel", 72'(acc_q), 72'd1);
        checkOutput("scoreboard has entry", 72'(sb.size() != 0), 72'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("window_out", bus.window_out, e.win);
          checkOutput("out_x", 72'(bus.out_x), 72'(e.x));
          checkOutput("out_y", 72'(bus.out_y), 72'(e.y));
          checkOutput("frame_done", 72'(bus.frame_done), 72'(e.fd));
        end
        if (median_on) checkOutput("median", 72'(median9(bus.window_out)), 72'd255);
      end else if (bus.frame_done) begin
        checkOutput("frame_done without window", 72'(bus.frame_done), 72'd0);
      end
    end
  end

  initial begin
    bus.pixel_in    = 8'h00;
    bus.pixel_valid = 1'b0;
    bus.in_sof      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset window_out", bus.window_out, 72'd0);
    checkOutput("reset window_valid", 72'(bus.window_valid), 72'd0);
    checkOutput("reset out_x", 72'(bus.out_x), 72'd0);
    checkOutput("reset out_y", 72'(bus.out_y), 72'd0);
    checkOutput("reset frame_done", 72'(bus.frame_done), 72'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] test 1: single frame back-to-back");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(8'(k), 1'b1, k == 0);
      if (k == 9)  checkOutput("t1 no window before pixel 10", 72'(bus.window_valid), 72'd0);
      if (k == 10) begin
        checkOutput("t1 first window valid", 72'(bus.window_valid), 72'd1);
        checkOutput("t1 first window data", bus.window_out, 72'h0a0908_060504_020100);
        checkOutput("t1 first out_x", 72'(bus.out_x), 72'd1);
        checkOutput("t1 first out_y", 72'(bus.out_y), 72'd1);
      end
      if (k == 15) begin
        checkOutput("t1 last window data", bus.window_out, 72'h0f0e0d_0b0a09_070605);
        checkOutput("t1 last frame_done", 72'(bus.frame_done), 72'd1);
      end
    end
    endTest("t1", 4, 1);

    $display("[TB] test 2: random valid gaps");
    for (int k = 0; k < 16; k++) begin
      int gaps;
      gaps = $urandom_range(2, 0);
      for (int g = 0; g < gaps; g++)
        applyStimulus(8'($urandom), 1'b0, 1'($urandom_range(1, 0)));
      applyStimulus(8'(k), 1'b1, k == 0);
    end
    endTest("t2", 4, 1);

    $display("[TB] test 3: two frames without second sof");
    for (int k = 0; k < 16; k++) applyStimulus(8'(k), 1'b1, k == 0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(8'(100 + k), 1'b1, 1'b0);
      if (k == 10)
        checkOutput("t3 frame2 first window", bus.window_out, 72'h6e6d6c_6a6968_666564);
    end
    endTest("t3", 8, 2);

    $display("[TB] test 4: sof resync mid-frame");
    for (int k = 0; k < 7; k++) applyStimulus(8'(k), 1'b1, k == 0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(8'(50 + k), 1'b1, k == 0);
      if (k <= 10)
        checkOutput("t4 window timing after sof", 72'(bus.window_valid), 72'(k == 10));
      if (k == 10) begin
        checkOutput("t4 first out_x", 72'(bus.out_x), 72'd1);
        checkOutput("t4 first out_y", 72'(bus.out_y), 72'd1);
      end
    end
    endTest("t4", 4, 1);

    $display("[TB] test 5: async reset mid-frame");
    for (int k = 0; k < 10; k++) applyStimulus(8'(k + 20), 1'b1, k == 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t5 async window_out", bus.window_out, 72'd0);
    checkOutput("t5 async window_valid", 72'(bus.window_valid), 72'd0);
    checkOutput("t5 async frame_done", 72'(bus.frame_done), 72'd0);
    sb.delete();
    mx = 0;
    my = 0;
    bus.pixel_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(8'(200 + k), 1'b1, 1'b0);
      if (k <= 10)
        checkOutput("t5 window timing after reset", 72'(bus.window_valid), 72'(k == 10));
    end
    endTest("t5", 4, 1);

    $display("[TB] test 6: median chain with single dark pixel");
    median_on = 1'b1;
    for (int k = 0; k < 16; k++) begin
      applyStimulus((k == 5) ? 8'd0 : 8'd255, 1'b1, k == 0);
      if (k == 10)
        checkOutput("t6 dark pixel at byte 4", 72'(bus.window_out[39:32]), 72'd0);
    end
    endTest("t6", 4, 1);
    median_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
